ps2_kbd_rx: RTL and testbench

- Parametrised PS/2 keyboard receiver: clock sync, glitch filter, frame timeout, error reporting, configurable-depth FIFO.
- Output is a valid/ready stream of key events.
- Sits between the board PS/2 pins and the CPU/peripheral bus keyboard register.
- Next generation of the fixed 8-deep keyboard receiver; replaces its pulse-style read strobe with a proper handshake.

---
 rtl/ps2_kbd_rx_if.sv | 26 ++
 rtl/ps2_kbd_rx.sv | 257 +++++++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_rx_if.sv
// -----------------------------------------------------------------------------
// ps2_kbd_rx_if
//   Key-event stream between the PS/2 keyboard receiver and its consumer.
//
//   Handshake: out_valid/out_ready follow strict valid/ready rules. The source
//   holds out_valid and out_data stable until a cycle in which both out_valid
//   and out_ready are high. That cycle transfers exactly one event. out_ready
//   may be driven freely and never depends on out_valid being low.
//
//   Signals:
//     out_valid  source -> sink  event available
//     out_ready  sink -> source  sink accepts the event this cycle
//     out_data   source -> sink  {ext, brk, code[7:0]}
//
//   Modports:
//     master  the event source (receiver)
//     slave   the event sink (bus register / CPU side)
// -----------------------------------------------------------------------------
interface ps2_kbd_rx_if;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// ps2_kbd_rx
//   PS/2 keyboard receiver. Synchronises the raw PS/2 lines, glitch-filters the
//   clock, deframes 11-bit frames (start, 8 data LSB first, odd parity, stop),
//   reports parity/frame errors, aborts stalled frames after a timeout and
//   queues good bytes in a show-ahead FIFO drained by a valid/ready stream.
//
//   Optional build macro PS2_KBD_EVENT_DECODE_EN: when defined, 0xE0 and 0xF0
//   are absorbed as extended/break prefixes and folded into the following
//   event's ext/brk bits. When undefined every good byte is queued with
//   ext = brk = 0.
//
//   Ports:
//     clk, reset     system clock, synchronous active-high reset
//     ps2_clk        raw PS/2 clock (asynchronous)
//     ps2_data       raw PS/2 data (asynchronous)
//     evt            key-event stream (out_valid/out_ready/out_data)
//     fifo_level     number of entries held
//     overflow       sticky, an event was dropped on a full FIFO
//     overflow_clr   clears overflow (a same-cycle new overflow wins)
//     parity_err     one-cycle pulse, bad parity
//     frame_err      one-cycle pulse, stop bit 0 or timeout
//     err_count      saturating count of parity/frame errors
//     busy           receive FSM not idle
//     fsm_state      receive FSM state (0 idle, 1 shift, 2 check)
// -----------------------------------------------------------------------------
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    ps2_kbd_rx_if.master     evt,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic             parity_err,
    output logic             frame_err,
    output logic [7:0]       err_count,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    // ---------------- input synchronisers (idle-high lines) ----------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // ---------------- clock glitch filter and falling-edge strobe ----------
    // filt_cnt counts consecutive samples that disagree with filt_clk; any
    // agreeing sample restarts the count, so short glitches never get through.
    logic [FCNT_W-1:0] filt_cnt;
    logic              filt_clk;
    logic              filt_clk_q;
    logic              strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_q <= 1'b1;
        end else begin
            filt_clk_q <= filt_clk;
            if (clk_s == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign strobe = filt_clk_q & ~filt_clk;

    // ---------------- receive FSM ----------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       bitcnt;
    logic [9:0]       shreg;      // after 10 shifts: [7:0] data, [8] parity, [9] stop
    logic [TO_W-1:0]  to_cnt;
    logic             push_req;
    logic [9:0]       push_data;
    logic             stop_ok;
    logic             par_ok;
`ifdef PS2_KBD_EVENT_DECODE_EN
    logic             ext_pend;
    logic             brk_pend;
`endif

    assign stop_ok = shreg[9];
    assign par_ok  = ^shreg[8:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            to_cnt     <= '0;
            push_req   <= 1'b0;
            push_data  <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PS2_KBD_EVENT_DECODE_EN
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
`endif
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            push_req   <= 1'b0;
            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (strobe && !data_s) begin
                        state  <= S_SHIFT;
                        bitcnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (strobe) begin
                        to_cnt <= '0;
                        // LSB-first: each new bit enters at the top.
                        shreg  <= {data_s, shreg[9:1]};
                        if (bitcnt == 4'd9) begin
                            state <= S_CHECK;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= S_IDLE;
                        frame_err <= 1'b1;
`ifdef PS2_KBD_EVENT_DECODE_EN
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
`endif
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    state  <= S_IDLE;
                    to_cnt <= '0;
                    if (!stop_ok || !par_ok) begin
                        // A bad stop bit is reported as a frame error even
                        // if the parity is also wrong.
                        if (!stop_ok) frame_err  <= 1'b1;
                        else          parity_err <= 1'b1;
`ifdef PS2_KBD_EVENT_DECODE_EN
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
`endif
                    end else begin
`ifdef PS2_KBD_EVENT_DECODE_EN
                        if (shreg[7:0] == 8'hE0) begin
                            ext_pend <= 1'b1;
                        end else if (shreg[7:0] == 8'hF0) begin
                            brk_pend <= 1'b1;
                        end else begin
                            push_req  <= 1'b1;
                            push_data <= {ext_pend, brk_pend, shreg[7:0]};
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end
`else
                        push_req  <= 1'b1;
                        push_data <= {2'b00, shreg[7:0]};
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    // ---------------- error counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if ((parity_err || frame_err) && err_count != 8'hFF) begin
            err_count <= err_count + 1'b1;
        end
    end

    // ---------------- show-ahead FIFO ----------------
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign full          = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign evt.out_valid = (fifo_level != '0);
    assign evt.out_data  = evt.out_valid ? mem[rd_ptr] : '0;
    assign pop           = evt.out_valid && evt.out_ready;
    // A pop in the same cycle frees the slot, so a push to a full FIFO is
    // still accepted then.
    assign push_ok       = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            // New overflow takes priority over a same-cycle clear.
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (overflow_clr)    overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_kbd_rx
//   Self-checking bench for ps2_kbd_rx (FIFO_DEPTH=4, FILTER_LEN=4,
//   TIMEOUT_CYCLES=1000). Frames are driven with a 50-clk half period.
//   Expected key events go into exp_q when a frame is sent and are compared
//   against the FIFO head as the bench drains it. Build with or without
//   PS2_KBD_EVENT_DECODE_EN; the decode scenario picks its expectations.
// -----------------------------------------------------------------------------
module tb_ps2_kbd_rx;

    localparam int FIFO_DEPTH     = 4;
    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1;
    localparam int HALF           = 50;

    logic             clk = 1'b0;
    logic             reset;
    logic             ps2_clk;
    logic             ps2_data;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             overflow_clr;
    logic             parity_err;
    logic             frame_err;
    logic [7:0]       err_count;
    logic             busy;
    logic [1:0]       fsm_state;

    ps2_kbd_rx_if u_if ();

    int checks = 0;
    int errors = 0;
    int n_par  = 0;
    int n_frm  = 0;
    logic [9:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .evt          (u_if),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .err_count    (err_count),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    // Error pulse tally, sampled on the inactive edge.
    always @(negedge clk) begin
        if (parity_err) n_par++;
        if (frame_err)  n_frm++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        ps2_clk         = 1'b1;
        ps2_data        = 1'b1;
        overflow_clr    = 1'b0;
        u_if.out_ready  = 1'b0;
        exp_q.delete();
        tick(3);
        reset = 1'b0;
        tick(2);
    endtask

    // Sends frame bits 0..last (0 = start, 1-8 data, 9 parity, 10 stop).
    task automatic send_bits(input logic [7:0] b, input logic bad_par,
                             input logic stop, input int last);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i <= last; i++) begin
            ps2_data = f[i];
            tick(HALF / 2);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
            tick(HALF / 2);
        end
        ps2_data = 1'b1;
    endtask

    // Stop bit with the falling edge split out: returns 8 edges after the
    // fall; the caller spends exactly one tick before stop_rise.
    task automatic stop_fall();
        ps2_data = 1'b1;
        tick(HALF / 2);
        ps2_clk = 1'b0;
        tick(8);
    endtask

    task automatic stop_rise();
        tick(HALF - 9);
        ps2_clk = 1'b1;
        tick(HALF / 2);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({u_if.out_valid, u_if.out_data, fifo_level, overflow, parity_err, frame_err,
             err_count, busy, fsm_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b data=%03h level=%0d ovf=%0b perr=%0b ferr=%0b cnt=%0d busy=%0b st=%0d, required all 0",
                     u_if.out_valid, u_if.out_data, fifo_level, overflow, parity_err, frame_err,
                     err_count, busy, fsm_state);
        end
        // Reset in the middle of a frame with entries queued.
        send_bits(8'h21, 1'b0, 1'b1, 10);
        send_bits(8'h22, 1'b0, 1'b1, 10);
        checks++;
        if (fifo_level !== 2) begin
            errors++;
            $display("FAIL reset_prefill_level: level=%0d required 2", fifo_level);
        end
        send_bits(8'h23, 1'b0, 1'b1, 4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_midframe_busy: busy=%0b required 1", busy);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(300);
        checks++;
        if (fifo_level !== 0 || u_if.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe_discard: level=%0d valid=%0b busy=%0b required 0 0 0",
                     fifo_level, u_if.out_valid, busy);
        end
    endtask

    task automatic test_single();
        logic [9:0] e;
        int n;
        do_reset();
        exp_q.push_back(10'h01C);
        send_bits(8'h1C, 1'b0, 1'b1, 9);
        stop_fall();
        checks++;
        if (u_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: valid=%0b required 0 one edge after push", u_if.out_valid);
        end
        tick(1);
        checks++;
        if (u_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: valid=%0b required 1 two edges after stop strobe", u_if.out_valid);
        end
        stop_rise();
        checks++;
        if (fifo_level !== 1) begin
            errors++;
            $display("FAIL single_level: level=%0d required 1", fifo_level);
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== e) begin
                errors++;
                $display("FAIL single_pop: valid=%0b data=%03h required data=%03h", u_if.out_valid, u_if.out_data, e);
            end
            u_if.out_ready = 1'b1;
            tick(1);
            u_if.out_ready = 1'b0;
        end
        checks++;
        if (u_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: valid=%0b required 0", u_if.out_valid);
        end
    endtask

    task automatic test_parity_err();
        int p0, f0;
        do_reset();
        p0 = n_par;
        f0 = n_frm;
        send_bits(8'h1C, 1'b1, 1'b1, 10);
        tick(10);
        checks++;
        if (n_par - p0 !== 1 || n_frm - f0 !== 0) begin
            errors++;
            $display("FAIL parity_pulses: parity=%0d frame=%0d required 1 0", n_par - p0, n_frm - f0);
        end
        checks++;
        if (err_count !== 8'd1 || fifo_level !== 0) begin
            errors++;
            $display("FAIL parity_count: err_count=%0d level=%0d required 1 0", err_count, fifo_level);
        end
    endtask

    task automatic test_frame_err();
        int p0, f0;
        do_reset();
        p0 = n_par;
        f0 = n_frm;
        send_bits(8'h1C, 1'b0, 1'b0, 10);
        tick(10);
        checks++;
        if (n_frm - f0 !== 1 || n_par - p0 !== 0 || err_count !== 8'd1 || fifo_level !== 0) begin
            errors++;
            $display("FAIL frame_stop0: frame=%0d parity=%0d err_count=%0d level=%0d required 1 0 1 0",
                     n_frm - f0, n_par - p0, err_count, fifo_level);
        end
        // Bad parity and bad stop together: frame error only.
        send_bits(8'h1C, 1'b1, 1'b0, 10);
        tick(10);
        checks++;
        if (n_frm - f0 !== 2 || n_par - p0 !== 0 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL frame_both_bad: frame=%0d parity=%0d err_count=%0d required 2 0 2",
                     n_frm - f0, n_par - p0, err_count);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] e;
        int n, f0;
        do_reset();
        f0 = n_frm;
        send_bits(8'h55, 1'b0, 1'b1, 3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy_before: busy=%0b required 1", busy);
        end
        for (int i = 0; i < TIMEOUT_CYCLES + 200 && n_frm == f0; i++) tick(1);
        tick(2);
        checks++;
        if (n_frm - f0 !== 1) begin
            errors++;
            $display("FAIL timeout_frame_err: pulses=%0d required 1 within %0d cycles", n_frm - f0, TIMEOUT_CYCLES + 200);
        end
        checks++;
        if (busy !== 1'b0 || fifo_level !== 0 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL timeout_state: busy=%0b level=%0d err_count=%0d required 0 0 1", busy, fifo_level, err_count);
        end
        exp_q.push_back(10'h02A);
        send_bits(8'h2A, 1'b0, 1'b1, 10);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== e) begin
                errors++;
                $display("FAIL timeout_recover_pop: valid=%0b data=%03h required data=%03h", u_if.out_valid, u_if.out_data, e);
            end
            u_if.out_ready = 1'b1;
            tick(1);
            u_if.out_ready = 1'b0;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        ps2_data = 1'b0;
        tick(10);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(30);
        checks++;
        if (busy !== 1'b0 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL glitch_no_strobe: busy=%0b state=%0d required 0 0", busy, fsm_state);
        end
        ps2_data = 1'b1;
        tick(10);
    endtask

    task automatic test_overflow();
        logic [9:0] e;
        logic [7:0] b;
        int n;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            b = 8'h10 + 8'(i);
            if (i <= 4) exp_q.push_back({2'b00, b});
            send_bits(b, 1'b0, 1'b1, 10);
        end
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: level=%0d overflow=%0b required 4 1", fifo_level, overflow);
        end
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%0b required 0", overflow);
        end
        // Clear in the very cycle a dropped push sets it again.
        send_bits(8'h16, 1'b0, 1'b1, 9);
        stop_fall();
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        stop_rise();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clr_collide: overflow=%0b required 1", overflow);
        end
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        // Full FIFO: pop in the push cycle lets the push in.
        send_bits(8'h17, 1'b0, 1'b1, 9);
        stop_fall();
        e = exp_q.pop_front();
        checks++;
        if (u_if.out_data !== e) begin
            errors++;
            $display("FAIL ovf_pushpop_head: data=%03h required %03h", u_if.out_data, e);
        end
        u_if.out_ready = 1'b1;
        tick(1);
        u_if.out_ready = 1'b0;
        exp_q.push_back(10'h017);
        stop_rise();
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pushpop_full: level=%0d overflow=%0b required 4 0", fifo_level, overflow);
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== e) begin
                errors++;
                $display("FAIL ovf_pop: valid=%0b data=%03h required data=%03h", u_if.out_valid, u_if.out_data, e);
            end
            u_if.out_ready = 1'b1;
            tick(1);
            u_if.out_ready = 1'b0;
        end
        checks++;
        if (u_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: valid=%0b required 0", u_if.out_valid);
        end
    endtask

    task automatic test_decode();
        logic [9:0] e;
        int n;
        do_reset();
`ifdef PS2_KBD_EVENT_DECODE_EN
        exp_q.push_back(10'h375);
`else
        exp_q.push_back(10'h0E0);
        exp_q.push_back(10'h0F0);
        exp_q.push_back(10'h075);
`endif
        send_bits(8'hE0, 1'b0, 1'b1, 10);
        send_bits(8'hF0, 1'b0, 1'b1, 10);
        send_bits(8'h75, 1'b0, 1'b1, 10);
        checks++;
        if (fifo_level !== LVL_W'(exp_q.size())) begin
            errors++;
            $display("FAIL decode_level_a: level=%0d required %0d", fifo_level, exp_q.size());
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== e) begin
                errors++;
                $display("FAIL decode_pop_a: valid=%0b data=%03h required data=%03h", u_if.out_valid, u_if.out_data, e);
            end
            u_if.out_ready = 1'b1;
            tick(1);
            u_if.out_ready = 1'b0;
        end
`ifdef PS2_KBD_EVENT_DECODE_EN
        exp_q.push_back(10'h11C);
`else
        exp_q.push_back(10'h0F0);
        exp_q.push_back(10'h01C);
`endif
        send_bits(8'hF0, 1'b0, 1'b1, 10);
        send_bits(8'h1C, 1'b0, 1'b1, 10);
        checks++;
        if (fifo_level !== LVL_W'(exp_q.size())) begin
            errors++;
            $display("FAIL decode_level_b: level=%0d required %0d", fifo_level, exp_q.size());
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== e) begin
                errors++;
                $display("FAIL decode_pop_b: valid=%0b data=%03h required data=%03h", u_if.out_valid, u_if.out_data, e);
            end
            u_if.out_ready = 1'b1;
            tick(1);
            u_if.out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        logic [7:0] b;
        int n;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(8'h01, 8'hDF));
            exp_q.push_back({2'b00, b});
            send_bits(b, 1'b0, 1'b1, 10);
        end
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL b2b_level: level=%0d required 2", fifo_level);
        end
        // Push and pop in the same cycle at a partial level.
        b = 8'($urandom_range(8'h01, 8'hDF));
        send_bits(b, 1'b0, 1'b1, 9);
        stop_fall();
        e = exp_q.pop_front();
        checks++;
        if (u_if.out_data !== e) begin
            errors++;
            $display("FAIL b2b_pushpop_head: data=%03h required %03h", u_if.out_data, e);
        end
        u_if.out_ready = 1'b1;
        tick(1);
        u_if.out_ready = 1'b0;
        exp_q.push_back({2'b00, b});
        stop_rise();
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL b2b_pushpop_level: level=%0d required 2", fifo_level);
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (u_if.out_valid !== 1'b1 || u_if.out_data !== e) begin
                errors++;
                $display("FAIL b2b_pop: valid=%0b data=%03h required data=%03h", u_if.out_valid, u_if.out_data, e);
            end
            u_if.out_ready = 1'b1;
            tick(1);
            u_if.out_ready = 1'b0;
        end
        checks++;
        if (u_if.out_valid !== 1'b0 || fifo_level !== 0) begin
            errors++;
            $display("FAIL b2b_empty: valid=%0b level=%0d required 0 0", u_if.out_valid, fifo_level);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_parity_err();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_overflow();
        test_decode();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
